// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches floor calls into a pending bitmap,
// sweeps one floor per TRAVEL_CYCLES and holds the door for DOOR_CYCLES at each stop.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]      T_LOAD = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0]      D_LOAD = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0]      ONE    = TW'(1);
  localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]   NF_W   = (FLOOR_W+1)'(NUM_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t                  state, state_nx;
  logic [FLOOR_W-1:0]      floor_nx, step_floor;
  logic                    dir_nx, arrive_nx;
  logic [TW-1:0]           timer, timer_nx;
  logic [NUM_FLOORS-1:0]   req_hot, cur_hot, step_hot, above, below, clr, req_set;
  logic                    in_range, same_req, here, ahead, behind;

  always_comb begin
    in_range   = ({1'b0, req_floor} < NF_W);
    if (state == MOVE_UP)
      step_floor = (curr_floor == TOP) ? curr_floor : curr_floor + FLOOR_W'(1);
    else
      step_floor = (curr_floor == '0) ? curr_floor : curr_floor - FLOOR_W'(1);
    for (int i = 0; i < NUM_FLOORS; i++) begin
      req_hot[i]  = req_valid && in_range && (req_floor == FLOOR_W'(i));
      cur_hot[i]  = (curr_floor == FLOOR_W'(i));
      step_hot[i] = (step_floor == FLOOR_W'(i));
      above[i]    = (FLOOR_W'(i) > curr_floor);
      below[i]    = (FLOOR_W'(i) < curr_floor);
    end
    here     = |(pending & cur_hot);
    ahead    = dir_up ? |(pending & above) : |(pending & below);
    behind   = dir_up ? |(pending & below) : |(pending & above);
    // A call for the floor whose door is already open only extends the dwell.
    same_req = (state == DOOR) && req_valid && (req_floor == curr_floor);
    req_set  = req_hot & ~({NUM_FLOORS{same_req}} & cur_hot);
  end

  always_comb begin
    state_nx  = state;
    floor_nx  = curr_floor;
    dir_nx    = dir_up;
    timer_nx  = timer;
    arrive_nx = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (here) begin
          state_nx  = DOOR;
          timer_nx  = D_LOAD;
          arrive_nx = 1'b1;
          clr       = cur_hot;
        end else if (ahead) begin
          state_nx = dir_up ? MOVE_UP : MOVE_DOWN;
          timer_nx = T_LOAD;
        end else if (behind) begin
          dir_nx   = ~dir_up;
          state_nx = dir_up ? MOVE_DOWN : MOVE_UP;
          timer_nx = T_LOAD;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer <= ONE) begin
          floor_nx = step_floor;
          if (|(pending & step_hot)) begin
            state_nx  = DOOR;
            timer_nx  = D_LOAD;
            arrive_nx = 1'b1;
            clr       = step_hot;
          end else begin
            timer_nx = T_LOAD;
          end
        end else begin
          timer_nx = timer - ONE;
        end
      end
      DOOR: begin
        if (same_req || door_hold) begin
          timer_nx = D_LOAD;
        end else if (timer <= ONE) begin
          if (ahead) begin
            state_nx = dir_up ? MOVE_UP : MOVE_DOWN;
            timer_nx = T_LOAD;
          end else if (behind) begin
            dir_nx   = ~dir_up;
            state_nx = dir_up ? MOVE_DOWN : MOVE_UP;
            timer_nx = T_LOAD;
          end else begin
            state_nx = IDLE;
            timer_nx = '0;
          end
        end else begin
          timer_nx = timer - ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      curr_floor <= '0;
      dir_up     <= 1'b1;
      timer      <= '0;
      pending    <= '0;
      arrived    <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      curr_floor <= floor_nx;
      dir_up     <= dir_nx;
      timer      <= timer_nx;
      // Arrival clears the stop's bit even if a call for it lands on the same edge.
      pending    <= (pending | req_set) & ~clr;
      arrived    <= arrive_nx;
      req_err    <= req_valid && !in_range;
    end
  end

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = (state == DOOR);

endmodule
